// File: rtl/aes256_io_ctrl.sv
// Byte-serial key/plaintext loader and result streamer around a combinational AES-256 core.
// Optional feature: define AES_KEY_REUSE_EN to add key_reuse, which skips the key fetch once a key is loaded.
module aes256_io_ctrl #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
`ifdef AES_KEY_REUSE_EN
  input  logic         key_reuse,
`endif
  output logic [4:0]   key_addr,
  input  logic [7:0]   key_dat,
  output logic [3:0]   inp_addr,
  input  logic [7:0]   inp_dat,
  output logic [255:0] core_key,
  output logic [127:0] core_inp,
  input  logic [127:0] core_out,
  output logic [3:0]   outp_addr,
  output logic [7:0]   outp_dat,
  output logic         outp_we,
  output logic         busy,
  output logic         done
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD_KEY, LOAD_INP, DRAIN, SETTLE, WRITE, DONE} state_t;

  state_t          state_q, state_d;
  logic [4:0]      key_addr_q, key_addr_d;
  logic [3:0]      inp_addr_q, inp_addr_d;
  logic            key_pend_q, key_pend_d;
  logic [4:0]      key_lane_q, key_lane_d;
  logic            inp_pend_q, inp_pend_d;
  logic [3:0]      inp_lane_q, inp_lane_d;
  logic            key_loaded_q, key_loaded_d;
  logic [SW-1:0]   settle_cnt_q, settle_cnt_d;
  logic [127:0]    cap_q, cap_d;
  logic [255:0]    core_key_q, core_key_d;
  logic [127:0]    core_inp_q, core_inp_d;
  logic [3:0]      outp_addr_q, outp_addr_d;
  logic [7:0]      outp_dat_q, outp_dat_d;
  logic            outp_we_q, outp_we_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            reuse_ok;

  always_comb begin
`ifdef AES_KEY_REUSE_EN
    reuse_ok = key_reuse & key_loaded_q;
`else
    reuse_ok = 1'b0;
`endif
    state_d      = state_q;
    key_addr_d   = key_addr_q;
    inp_addr_d   = inp_addr_q;
    key_pend_d   = 1'b0;
    key_lane_d   = key_addr_q;
    inp_pend_d   = 1'b0;
    inp_lane_d   = inp_addr_q;
    key_loaded_d = key_loaded_q;
    settle_cnt_d = settle_cnt_q;
    cap_d        = cap_q;
    core_key_d   = core_key_q;
    core_inp_d   = core_inp_q;
    outp_addr_d  = 4'd0;
    outp_dat_d   = 8'd0;
    outp_we_d    = 1'b0;
    done_d       = 1'b0;

    // Read data arrives one cycle after its address; retire it into the lane remembered for it.
    if (key_pend_q) core_key_d[{~key_lane_q, 3'b000} +: 8] = key_dat;
    if (inp_pend_q) core_inp_d[{~inp_lane_q, 3'b000} +: 8] = inp_dat;

    case (state_q)
      IDLE: begin
        if (start) state_d = reuse_ok ? LOAD_INP : LOAD_KEY;
      end
      LOAD_KEY: begin
        key_pend_d = 1'b1;
        if (key_addr_q == 5'd31) begin
          key_addr_d   = 5'd0;
          key_loaded_d = 1'b1;
          state_d      = LOAD_INP;
        end else begin
          key_addr_d = key_addr_q + 5'd1;
        end
      end
      LOAD_INP: begin
        inp_pend_d = 1'b1;
        if (inp_addr_q == 4'd15) begin
          inp_addr_d = 4'd0;
          state_d    = DRAIN;
        end else begin
          inp_addr_d = inp_addr_q + 4'd1;
        end
      end
      DRAIN: begin
        settle_cnt_d = '0;
        state_d      = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          cap_d      = core_out;
          outp_we_d  = 1'b1;
          outp_dat_d = core_out[127:120];
          state_d    = WRITE;
        end else begin
          settle_cnt_d = settle_cnt_q + SW'(1);
        end
      end
      WRITE: begin
        if (outp_addr_q == 4'd15) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          outp_we_d   = 1'b1;
          outp_addr_d = outp_addr_q + 4'd1;
          outp_dat_d  = cap_q[{~outp_addr_d, 3'b000} +: 8];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      key_addr_q   <= 5'd0;
      inp_addr_q   <= 4'd0;
      key_pend_q   <= 1'b0;
      key_lane_q   <= 5'd0;
      inp_pend_q   <= 1'b0;
      inp_lane_q   <= 4'd0;
      key_loaded_q <= 1'b0;
      settle_cnt_q <= '0;
      cap_q        <= 128'd0;
      core_key_q   <= 256'd0;
      core_inp_q   <= 128'd0;
      outp_addr_q  <= 4'd0;
      outp_dat_q   <= 8'd0;
      outp_we_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_addr_q   <= key_addr_d;
      inp_addr_q   <= inp_addr_d;
      key_pend_q   <= key_pend_d;
      key_lane_q   <= key_lane_d;
      inp_pend_q   <= inp_pend_d;
      inp_lane_q   <= inp_lane_d;
      key_loaded_q <= key_loaded_d;
      settle_cnt_q <= settle_cnt_d;
      cap_q        <= cap_d;
      core_key_q   <= core_key_d;
      core_inp_q   <= core_inp_d;
      outp_addr_q  <= outp_addr_d;
      outp_dat_q   <= outp_dat_d;
      outp_we_q    <= outp_we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign key_addr  = key_addr_q;
  assign inp_addr  = inp_addr_q;
  assign core_key  = core_key_q;
  assign core_inp  = core_inp_q;
  assign outp_addr = outp_addr_q;
  assign outp_dat  = outp_dat_q;
  assign outp_we   = outp_we_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_aes256_io_ctrl.sv
// Directed bench for aes256_io_ctrl: two instances (settle window 4 and 1) with a stub core
// and synchronous byte memories; every cycle of each run is compared against a timing model.
`timescale 1ns/1ps
module tb_aes256_io_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   logic start0;
   logic start1;
`ifdef AES_KEY_REUSE_EN
   logic keyReuse;
`endif
   logic [127:0] pert;
   logic sel;

   logic [7:0] keyMem [32];
   logic [7:0] inpMem [16];

   logic [4:0]   keyAddr0, keyAddr1;
   logic [7:0]   keyDat0, keyDat1;
   logic [3:0]   inpAddr0, inpAddr1;
   logic [7:0]   inpDat0, inpDat1;
   logic [255:0] coreKey0, coreKey1;
   logic [127:0] coreInp0, coreInp1;
   logic [127:0] coreOut0, coreOut1;
   logic [3:0]   outpAddr0, outpAddr1;
   logic [7:0]   outpDat0, outpDat1;
   logic         outpWe0, outpWe1;
   logic         busy0, busy1;
   logic         done0, done1;

   logic [7:0]   expByte [16];
   logic [255:0] expKey;
   logic [127:0] expInp;

   int checks = 0;
   int errors = 0;

   // Free-running 10 ns clock shared by both instances.
   always #5 clk = ~clk;

   // Synchronous byte memories: data for an address shows up one cycle later.
   always @(posedge clk) begin
      keyDat0 <= keyMem[keyAddr0];
      keyDat1 <= keyMem[keyAddr1];
      inpDat0 <= inpMem[inpAddr0];
      inpDat1 <= inpMem[inpAddr1];
   end

   // Stub core: output is the input block XORed with the upper key half; pert lets a run disturb
   // the second instance's core output after its capture point.
   assign coreOut0 = coreInp0 ^ coreKey0[255:128];
   assign coreOut1 = coreInp1 ^ coreKey1[255:128] ^ pert;

   // Main instance with the default settle window.
   aes256_io_ctrl #(.SETTLE_CYCLES(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0),
`ifdef AES_KEY_REUSE_EN
      .key_reuse(keyReuse),
`endif
      .key_addr(keyAddr0), .key_dat(keyDat0), .inp_addr(inpAddr0), .inp_dat(inpDat0),
      .core_key(coreKey0), .core_inp(coreInp0), .core_out(coreOut0),
      .outp_addr(outpAddr0), .outp_dat(outpDat0), .outp_we(outpWe0),
      .busy(busy0), .done(done0)
   );

   // Second instance exercising the shortest settle window.
   aes256_io_ctrl #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1),
`ifdef AES_KEY_REUSE_EN
      .key_reuse(1'b0),
`endif
      .key_addr(keyAddr1), .key_dat(keyDat1), .inp_addr(inpAddr1), .inp_dat(inpDat1),
      .core_key(coreKey1), .core_inp(coreInp1), .core_out(coreOut1),
      .outp_addr(outpAddr1), .outp_dat(outpDat1), .outp_we(outpWe1),
      .busy(busy1), .done(done1)
   );

   // Observation mux so the checking tasks can look at whichever instance is under test.
   logic [4:0]   obsKeyAddr;
   logic [3:0]   obsInpAddr;
   logic [255:0] obsCoreKey;
   logic [127:0] obsCoreInp;
   logic [3:0]   obsOutpAddr;
   logic [7:0]   obsOutpDat;
   logic         obsOutpWe, obsBusy, obsDone;
   assign obsKeyAddr  = sel ? keyAddr1  : keyAddr0;
   assign obsInpAddr  = sel ? inpAddr1  : inpAddr0;
   assign obsCoreKey  = sel ? coreKey1  : coreKey0;
   assign obsCoreInp  = sel ? coreInp1  : coreInp0;
   assign obsOutpAddr = sel ? outpAddr1 : outpAddr0;
   assign obsOutpDat  = sel ? outpDat1  : outpDat0;
   assign obsOutpWe   = sel ? outpWe1   : outpWe0;
   assign obsBusy     = sel ? busy1     : busy0;
   assign obsDone     = sel ? done1     : done0;

   // One comparison: counts it, and on a difference counts an error and reports it.
   task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Advance to 1 ns after the next rising edge, where outputs are sampled and inputs driven.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive start of the selected instance.
   task automatic setStart(input logic v);
      if (sel) start1 = v;
      else     start0 = v;
   endtask

   // Raise start on the selected instance and let the sampling edge T pass; we end in cycle T+1.
   task automatic applyStimulus();
      setStart(1'b1);
      tick();
   endtask

   // Expected key, block and result bytes derived from the memory contents and the stub core.
   task automatic buildModel();
      for (int i = 0; i < 32; i++) expKey[255 - 8*i -: 8] = keyMem[i];
      for (int i = 0; i < 16; i++) begin
         expInp[127 - 8*i -: 8] = inpMem[i];
         expByte[i] = inpMem[i] ^ keyMem[i];
      end
   endtask

   // Everything a reset leaves behind must read as zero.
   task automatic checkIdle(input string tag);
      checkOutput({tag, ".busy"},     256'(obsBusy),     256'(0));
      checkOutput({tag, ".keyAddr"},  256'(obsKeyAddr),  256'(0));
      checkOutput({tag, ".inpAddr"},  256'(obsInpAddr),  256'(0));
      checkOutput({tag, ".outpWe"},   256'(obsOutpWe),   256'(0));
      checkOutput({tag, ".outpAddr"}, 256'(obsOutpAddr), 256'(0));
      checkOutput({tag, ".outpDat"},  256'(obsOutpDat),  256'(0));
      checkOutput({tag, ".done"},     256'(obsDone),     256'(0));
      checkOutput({tag, ".coreKey"},  obsCoreKey,        256'(0));
      checkOutput({tag, ".coreInp"},  256'(obsCoreInp),  256'(0));
   endtask

   // Cycle-by-cycle check of one run starting at cycle T+1. mode 0: drop start after T;
   // 1: also pulse start at T+10 and on the done cycle; 2: keep start high; 3: like 0 and
   // disturb the stub core from T+52 on.
   task automatic checkRun(input int settle, input bit reuse, input int mode, input int maxRel);
      int a;
      int w0;
      logic [7:0] expDat;
      a  = reuse ? 0 : 32;
      w0 = a + 18 + settle;
      for (int rel = 1; rel <= maxRel; rel++) begin
         if (rel >= w0 && rel < w0 + 16) expDat = expByte[rel - w0];
         else                            expDat = 8'h00;
         checkOutput($sformatf("busy@%0d", rel), 256'(obsBusy), 256'(rel <= w0 + 16));
         checkOutput($sformatf("keyAddr@%0d", rel), 256'(obsKeyAddr),
                     256'((!reuse && rel <= 32) ? rel - 1 : 0));
         checkOutput($sformatf("inpAddr@%0d", rel), 256'(obsInpAddr),
                     256'((rel > a && rel <= a + 16) ? rel - a - 1 : 0));
         checkOutput($sformatf("outpWe@%0d", rel), 256'(obsOutpWe), 256'(rel >= w0 && rel < w0 + 16));
         checkOutput($sformatf("outpAddr@%0d", rel), 256'(obsOutpAddr),
                     256'((rel >= w0 && rel < w0 + 16) ? rel - w0 : 0));
         checkOutput($sformatf("outpDat@%0d", rel), 256'(obsOutpDat), 256'(expDat));
         checkOutput($sformatf("done@%0d", rel), 256'(obsDone), 256'(rel == w0 + 16));
         if (rel == a + 18) begin
            checkOutput($sformatf("coreKey@%0d", rel), obsCoreKey, expKey);
            checkOutput($sformatf("coreInp@%0d", rel), 256'(obsCoreInp), 256'(expInp));
         end
         if (rel == 1 && mode != 2) setStart(1'b0);
         if (mode == 1 && (rel == 10 || rel == w0 + 16)) setStart(1'b1);
         if (mode == 1 && (rel == 11 || rel == w0 + 17)) setStart(1'b0);
         if (mode == 3 && rel == 52) pert = {128{1'b1}};
         tick();
      end
   endtask

   // Directed scenario sequence.
   initial begin
      rst_n  = 1'b0;
      start0 = 1'b0;
      start1 = 1'b0;
      pert   = 128'd0;
      sel    = 1'b0;
`ifdef AES_KEY_REUSE_EN
      keyReuse = 1'b0;
`endif
      for (int i = 0; i < 32; i++) keyMem[i] = 8'(i);
      for (int i = 0; i < 16; i++) inpMem[i] = 8'(8'h11 * i);
      buildModel();
      tick();
      tick();
      tick();

      // Reset state of both instances.
      sel = 1'b0;
      checkIdle("reset0");
      sel = 1'b1;
      checkIdle("reset1");
      sel = 1'b0;
      rst_n = 1'b1;
      tick();

`ifdef AES_KEY_REUSE_EN
      // key_reuse on the first start after reset still fetches the whole key.
      keyReuse = 1'b1;
      applyStimulus();
      checkRun(4, 1'b0, 0, 72);
      keyReuse = 1'b0;
`endif

      // Basic run with start pulses at T+10 and on the done cycle, both ignored.
      applyStimulus();
      checkRun(4, 1'b0, 1, 72);

      // start held high: a second run begins from the IDLE cycle after done.
      start0 = 1'b1;
      tick();
      checkRun(4, 1'b0, 2, 71);
      checkRun(4, 1'b0, 0, 72);

      // Reset at T+40 aborts the run; a fresh run then yields the same bytes.
      applyStimulus();
      checkRun(4, 1'b0, 0, 39);
      rst_n = 1'b0;
      tick();
      checkIdle("midReset");
      rst_n = 1'b1;
      tick();
      checkIdle("afterReset");
      applyStimulus();
      checkRun(4, 1'b0, 0, 72);

      // Shortest settle window; core output disturbed after capture must not reach the writes.
      sel = 1'b1;
      applyStimulus();
      checkRun(1, 1'b0, 3, 69);
      pert = 128'd0;
      sel = 1'b0;

`ifdef AES_KEY_REUSE_EN
      // Key reuse with a new block: no key fetch, key kept, done at T+38.
      for (int i = 0; i < 16; i++) inpMem[i] = 8'(8'h5A + 3 * i);
      buildModel();
      keyReuse = 1'b1;
      applyStimulus();
      checkRun(4, 1'b1, 0, 40);
      keyReuse = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
